// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage plus the Memory-Writeback register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of masking them.
package memory_stage_pkg;

  typedef struct packed {
    logic        memWrt;
    logic [31:0] aluOut;
    logic [31:0] pcNext;
    logic [31:0] lrWrtData;
    logic [1:0]  flWrtData;
    logic [1:0]  resultSel;
    logic        regWrtEn;
    logic        lrWrite;
    logic        flWrite;
    logic [4:0]  regWrtSel;
  } ex_me_t;

  typedef struct packed {
    logic        valid;
    logic        regWrtEn;
    logic        lrWrite;
    logic        flWrite;
    logic        memErr;
    logic [31:0] aluOut;
    logic [31:0] memData;
    logic [31:0] pcNext;
    logic [31:0] lrWrtData;
    logic [1:0]  flWrtData;
    logic [1:0]  resultSel;
    logic [4:0]  regWrtSel;
  } me_wb_t;

endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ExMe_out_valid,
  input  logic [31:0] ExMe_out_alu_out,
  input  logic [31:0] ExMe_out_reg_2,
  input  logic [31:0] ExMe_out_PC_next,
  input  logic [31:0] ExMe_out_LR_wrt_data,
  input  logic [1:0]  ExMe_out_FL_wrt_data,
  input  logic        ExMe_out_mem_en,
  input  logic        ExMe_out_mem_wrt,
  input  logic [1:0]  ExMe_out_result_sel,
  input  logic        ExMe_out_reg_wrt_en,
  input  logic        ExMe_out_LR_write,
  input  logic        ExMe_out_FL_write,
  input  logic [4:0]  ExMe_out_reg_wrt_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        MeWb_out_valid,
  output logic        MeWb_out_reg_wrt_en,
  output logic        MeWb_out_LR_write,
  output logic        MeWb_out_FL_write,
  output logic [31:0] MeWb_out_alu_out,
  output logic [31:0] MeWb_out_mem_data,
  output logic [31:0] MeWb_out_PC_next,
  output logic [31:0] MeWb_out_LR_wrt_data,
  output logic [1:0]  MeWb_out_FL_wrt_data,
  output logic [1:0]  MeWb_out_result_sel,
  output logic [4:0]  MeWb_out_reg_wrt_sel,
  output logic        MeWb_out_mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] LastWait = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] waitCnt;
  ex_me_t      cur;
  ex_me_t      held;
  me_wb_t      mewb;
  logic        isMemOp;
  logic        misaligned;
  logic        launch;
  logic        timeout;

  // An aborted access still retires, but must not touch architectural state.
  function automatic me_wb_t retire(
    input ex_me_t      i,
    input logic [31:0] data,
    input logic        err
  );
    me_wb_t w;
    w.valid     = 1'b1;
    w.regWrtEn  = i.regWrtEn & ~err;
    w.lrWrite   = i.lrWrite & ~err;
    w.flWrite   = i.flWrite & ~err;
    w.memErr    = err;
    w.aluOut    = i.aluOut;
    w.memData   = data;
    w.pcNext    = i.pcNext;
    w.lrWrtData = i.lrWrtData;
    w.flWrtData = i.flWrtData;
    w.resultSel = i.resultSel;
    w.regWrtSel = i.regWrtSel;
    return w;
  endfunction

  assign cur = '{
    memWrt:    ExMe_out_mem_wrt,
    aluOut:    ExMe_out_alu_out,
    pcNext:    ExMe_out_PC_next,
    lrWrtData: ExMe_out_LR_wrt_data,
    flWrtData: ExMe_out_FL_wrt_data,
    resultSel: ExMe_out_result_sel,
    regWrtEn:  ExMe_out_reg_wrt_en,
    lrWrite:   ExMe_out_LR_write,
    flWrite:   ExMe_out_FL_write,
    regWrtSel: ExMe_out_reg_wrt_sel
  };

  assign isMemOp = ExMe_out_valid & ExMe_out_mem_en;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = isMemOp & (ExMe_out_alu_out[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign launch  = (state == IDLE) && isMemOp && !misaligned;
  assign timeout = (state == BUSY) && !mem_ready
                && (waitCnt == LastWait);

  assign stall = !rst
              && (launch || ((state == BUSY) && !mem_ready && !timeout));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      held      <= '0;
      mewb      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            state     <= BUSY;
            waitCnt   <= '0;
            held      <= cur;
            mem_req   <= 1'b1;
            mem_we    <= ExMe_out_mem_wrt;
            mem_addr  <= {ExMe_out_alu_out[31:2], 2'b00};
            mem_wdata <= ExMe_out_reg_2;
            mewb      <= '0;
          end else if (!ExMe_out_valid) begin
            mewb <= '0;
          end else begin
            mewb <= retire(cur, '0, misaligned);
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mewb    <= retire(held, held.memWrt ? '0 : mem_rdata, 1'b0);
          end else if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mewb    <= retire(held, '0, 1'b1);
          end else begin
            waitCnt <= waitCnt + 16'd1;
            mewb    <= '0;
          end
        end
      endcase
    end
  end

  assign MeWb_out_valid       = mewb.valid;
  assign MeWb_out_reg_wrt_en  = mewb.regWrtEn;
  assign MeWb_out_LR_write    = mewb.lrWrite;
  assign MeWb_out_FL_write    = mewb.flWrite;
  assign MeWb_out_mem_err     = mewb.memErr;
  assign MeWb_out_alu_out     = mewb.aluOut;
  assign MeWb_out_mem_data    = mewb.memData;
  assign MeWb_out_PC_next     = mewb.pcNext;
  assign MeWb_out_LR_wrt_data = mewb.lrWrtData;
  assign MeWb_out_FL_wrt_data = mewb.flWrtData;
  assign MeWb_out_result_sel  = mewb.resultSel;
  assign MeWb_out_reg_wrt_sel = mewb.regWrtSel;

endmodule
